mem_stage_pipe: RTL and testbench
=================================

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning data-memory words; power of two.
REQ-003 SHALL have parameter BASE_ADDR, default 1024, meaning byte address of word 0.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, meaning extra memory-access cycles, range 0..15.
REQ-005 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_in  in  1  upstream instruction valid.
- alu_res_in  in  DATA_W  address, or passthrough result.
- val_rm_in  in  DATA_W  store data.
- dest_in  in  4  writeback register.
- wb_enable_in  in  1  writeback enable.
- mem_read_enable_in  in  1  load.
- mem_write_enable_in  in  1  store.
- stall_out  out  1  freeze upstream stages.
- valid_out  out  1  result valid.
- alu_res_out  out  DATA_W  registered alu_res_in.
- data_memory_out  out  DATA_W  load data.
- dest_out  out  4  registered dest_in.
- wb_enable_out  out  1  registered wb enable.
- mem_read_enable_out  out  1  registered load flag.
- misaligned_out  out  1  misaligned flag; present only with MEM_STAGE_ALIGN_CHK_EN.

Function
REQ-006 SHALL compute word index = ((alu_res_in - BASE_ADDR) >> 2) mod DEPTH; out-of-range addresses wrap.
REQ-007 SHALL implement FSM IDLE/BUSY with a 4-bit countdown counter cnt.
REQ-008 IDLE, valid_in with no memory op: SHALL register all outputs next edge, valid_out=1; latency 1; stall_out=0.
REQ-009 IDLE, valid memory op, WAIT_CYCLES=0: SHALL perform access at that edge; outputs valid next cycle; no stall.
REQ-010 IDLE, valid memory op, WAIT_CYCLES>0: SHALL latch the request, load cnt=WAIT_CYCLES-1, go BUSY; stall_out=1 combinationally that cycle.
REQ-011 BUSY, cnt!=0: SHALL decrement cnt, hold stall_out=1, valid_out=0.
REQ-012 BUSY, cnt=0: SHALL perform the access, register outputs with valid_out=1, return IDLE, stall_out=0.
REQ-013 Total stall SHALL be exactly WAIT_CYCLES cycles per memory op; load-to-valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-014 Stores SHALL write val_rm_in at one clock edge; loads SHALL return the word in data_memory_out; non-load data_memory_out=0.
REQ-015 Read and write both set: write SHALL win; mem_read_enable_out=0; data_memory_out=0.
REQ-016 valid_in=0 in IDLE: SHALL produce a bubble (valid_out=0, wb_enable_out=0); inputs ignored while BUSY.
REQ-017 Back-to-back memory ops SHALL each incur full WAIT_CYCLES stall; no overlap.

Reset
REQ-018 rst low SHALL asynchronously force IDLE, cnt=0, all outputs 0, including stall_out.
REQ-019 Reset mid-BUSY SHALL abort the pending access: no write occurs; memory contents are retained, not cleared.

Configuration
REQ-020 With MEM_STAGE_ALIGN_CHK_EN defined, alu_res_in[1:0]!=0 on a memory op SHALL set misaligned_out with valid_out, suppress the store, and force wb_enable_out=0.
REQ-021 Without MEM_STAGE_ALIGN_CHK_EN, misaligned_out SHALL be absent and address bits [1:0] ignored.

Structure
REQ-022 Package mem_stage_pkg SHALL hold the FSM state typedef, the counter width constant and the parameter defaults.
REQ-023 The storage array SHALL be sub-module data_memory_param (DATA_W, DEPTH; synchronous write, combinational read, no reset).

Verification
REQ-024 WAIT_CYCLES=2: store 0xDEADBEEF @1024, load @1024 -> stall_out high 2 cycles each; load data_memory_out=0xDEADBEEF, valid 3 cycles after issue.
REQ-025 Non-memory op, alu_res_in=0x55, dest_in=3 -> next cycle alu_res_out=0x55, dest_out=3, valid_out=1, stall_out never high.
REQ-026 DEPTH=64: store 0x11 @1024+256 -> load @1024 returns 0x11 (wrap).
REQ-027 rst low in second BUSY cycle of store 0x77 @1028 -> outputs 0, FSM IDLE; later load @1028 returns prior contents, not 0x77.
REQ-028 Read+write together, val_rm_in=0x5 @1032 -> data_memory_out=0, mem_read_enable_out=0; later load @1032 returns 0x5.
REQ-029 MEM_STAGE_ALIGN_CHK_EN: store @1025 -> misaligned_out=1, wb_enable_out=0, memory unchanged.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and parameter defaults for the memory pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned DEPTH_DEF       = 64;
  localparam int unsigned BASE_ADDR_DEF   = 1024;
  localparam int unsigned WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/data_memory_param.sv
// Word-addressed data storage: synchronous write, combinational read, no reset.
module data_memory_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory pipeline stage with configurable access wait states.
// Optional alignment checking is enabled by defining MEM_STAGE_ALIGN_CHK_EN.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [3:0]        dest_in,
  input  logic              wb_enable_in,
  input  logic              mem_read_enable_in,
  input  logic              mem_write_enable_in,
  output logic              stall_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] data_memory_out,
  output logic [3:0]        dest_out,
  output logic              wb_enable_out,
  output logic              mem_read_enable_out
`ifdef MEM_STAGE_ALIGN_CHK_EN
  ,
  output logic              misaligned_out
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              latch, complete, stall;

  logic [DATA_W-1:0] req_addr_q, req_data_q;
  logic [3:0]        req_dest_q;
  logic              req_wb_q, req_rd_q, req_wr_q;

  logic [DATA_W-1:0] cur_addr, cur_data, mem_rdata;
  logic [3:0]        cur_dest;
  logic              cur_wb, cur_rd, cur_wr, use_req, mis, mem_we;
  logic [AW-1:0]     mem_idx;

  logic              valid_q, wb_q, rd_q;
  logic [DATA_W-1:0] alu_q, dmo_q;
  logic [3:0]        dest_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch    = 1'b0;
    complete = 1'b0;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if ((mem_read_enable_in || mem_write_enable_in) && (WAIT_CYCLES != 0)) begin
            latch   = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_BUSY;
            stall   = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          stall = 1'b1;
        end else begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_out = rst & stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr_q <= '0;
      req_data_q <= '0;
      req_dest_q <= '0;
      req_wb_q   <= 1'b0;
      req_rd_q   <= 1'b0;
      req_wr_q   <= 1'b0;
    end else if (latch) begin
      req_addr_q <= alu_res_in;
      req_data_q <= val_rm_in;
      req_dest_q <= dest_in;
      req_wb_q   <= wb_enable_in;
      req_rd_q   <= mem_read_enable_in;
      req_wr_q   <= mem_write_enable_in;
    end
  end

  // A completing access comes straight from the inputs when issued from IDLE
  // (no wait states or no memory op), otherwise from the latched request.
  assign use_req  = (state_q == S_BUSY);
  assign cur_addr = use_req ? req_addr_q : alu_res_in;
  assign cur_data = use_req ? req_data_q : val_rm_in;
  assign cur_dest = use_req ? req_dest_q : dest_in;
  assign cur_wb   = use_req ? req_wb_q   : wb_enable_in;
  assign cur_rd   = use_req ? req_rd_q   : mem_read_enable_in;
  assign cur_wr   = use_req ? req_wr_q   : mem_write_enable_in;

`ifdef MEM_STAGE_ALIGN_CHK_EN
  assign mis = (cur_rd | cur_wr) & (cur_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign mem_idx = AW'((cur_addr - DATA_W'(BASE_ADDR)) >> 2);
  assign mem_we  = complete & cur_wr & ~mis;

  data_memory_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_idx),
    .wdata_i (cur_data),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      dmo_q   <= '0;
      dest_q  <= '0;
      wb_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else if (complete) begin
      valid_q <= 1'b1;
      alu_q   <= cur_addr;
      dmo_q   <= (cur_rd & ~cur_wr) ? mem_rdata : '0;
      dest_q  <= cur_dest;
      wb_q    <= cur_wb & ~mis;
      rd_q    <= cur_rd & ~cur_wr;
    end else begin
      valid_q <= 1'b0;
      wb_q    <= 1'b0;
      rd_q    <= 1'b0;
    end
  end

`ifdef MEM_STAGE_ALIGN_CHK_EN
  logic mis_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          mis_q <= 1'b0;
    else if (complete) mis_q <= mis;
    else               mis_q <= 1'b0;
  end
  assign misaligned_out = mis_q;
`endif

  assign valid_out           = valid_q;
  assign alu_res_out         = alu_q;
  assign data_memory_out     = dmo_q;
  assign dest_out            = dest_q;
  assign wb_enable_out       = wb_q;
  assign mem_read_enable_out = rd_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Self-checking bench for mem_stage_pipe: directed vector table, reset-abort
// sequence and randomized ops against a word-array reference model.
module tb_mem_stage_pipe;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned WAIT  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] alu_res_in, val_rm_in;
  logic [3:0]    dest_in;
  logic          wb_enable_in, mem_read_enable_in, mem_write_enable_in;
  logic          stall_out, valid_out, wb_enable_out, mem_read_enable_out;
  logic [DW-1:0] alu_res_out, data_memory_out;
  logic [3:0]    dest_out;
`ifdef MEM_STAGE_ALIGN_CHK_EN
  logic          misaligned_out;
`endif

  mem_stage_pipe #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_in            (valid_in),
    .alu_res_in          (alu_res_in),
    .val_rm_in           (val_rm_in),
    .dest_in             (dest_in),
    .wb_enable_in        (wb_enable_in),
    .mem_read_enable_in  (mem_read_enable_in),
    .mem_write_enable_in (mem_write_enable_in),
    .stall_out           (stall_out),
    .valid_out           (valid_out),
    .alu_res_out         (alu_res_out),
    .data_memory_out     (data_memory_out),
    .dest_out            (dest_out),
    .wb_enable_out       (wb_enable_out),
    .mem_read_enable_out (mem_read_enable_out)
`ifdef MEM_STAGE_ALIGN_CHK_EN
    ,
    .misaligned_out      (misaligned_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  dest;
    logic        wb, rd, wr;
  } op_t;

  typedef struct {
    int          lat, stalls;
    logic        vld;
    logic [31:0] alu, dmo;
    logic [3:0]  dest;
    logic        wb, rd, mis;
    bit          chk_dmo;
  } res_t;

  typedef struct {
    op_t         op;
    logic [31:0] exp_dmo;
    logic        exp_rd;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic is_mis(input op_t op);
`ifdef MEM_STAGE_ALIGN_CHK_EN
    return (op.rd || op.wr) && (op.addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Expected timing and passthrough fields, straight from the stage's rules.
  function automatic res_t rule_exp(input op_t op);
    res_t r;
    bit memop = op.rd || op.wr;
    r.lat     = memop ? WAIT + 1 : 1;
    r.stalls  = memop ? WAIT : 0;
    r.vld     = 1'b1;
    r.alu     = op.addr;
    r.dest    = op.dest;
    r.mis     = is_mis(op);
    r.wb      = op.wb && !r.mis;
    r.rd      = op.rd && !op.wr;
    r.dmo     = '0;
    r.chk_dmo = 1'b1;
    return r;
  endfunction

  // Reference memory: index arithmetic done in plain integers.
  task automatic model_apply(input op_t op, output logic [31:0] dmo, output bit kn);
    int unsigned idx = ((op.addr - BASE) >> 2) % DEPTH;
    dmo = '0;
    kn  = 1'b1;
    if (op.rd && !op.wr) begin
      dmo = mem_m[idx];
      kn  = known[idx];
    end
    if (op.wr && !is_mis(op)) begin
      mem_m[idx] = op.data;
      known[idx] = 1'b1;
    end
  endtask

  task automatic drive_op(input op_t op);
    valid_in            = 1'b1;
    alu_res_in          = op.addr;
    val_rm_in           = op.data;
    dest_in             = op.dest;
    wb_enable_in        = op.wb;
    mem_read_enable_in  = op.rd;
    mem_write_enable_in = op.wr;
  endtask

  task automatic drive_junk();
    valid_in            = 1'b0;
    alu_res_in          = $urandom;
    val_rm_in           = $urandom;
    dest_in             = 4'($urandom);
    wb_enable_in        = 1'($urandom);
    mem_read_enable_in  = 1'($urandom);
    mem_write_enable_in = 1'($urandom);
  endtask

  task automatic do_op(input op_t op, output res_t r);
    @(negedge clk);
    drive_op(op);
    #1 r.stalls = int'(stall_out);
    @(posedge clk);
    @(negedge clk);
    drive_junk();
    r.lat = 1;
    while (!valid_out && r.lat < 40) begin
      r.stalls += int'(stall_out);
      @(negedge clk);
      r.lat++;
    end
    r.vld  = valid_out;
    r.alu  = alu_res_out;
    r.dmo  = data_memory_out;
    r.dest = dest_out;
    r.wb   = wb_enable_out;
    r.rd   = mem_read_enable_out;
`ifdef MEM_STAGE_ALIGN_CHK_EN
    r.mis  = misaligned_out;
`else
    r.mis  = 1'b0;
`endif
    r.chk_dmo = 1'b1;
  endtask

  task automatic compare_res(input string tag, input res_t g, input res_t e);
    chk({tag, " valid"}, 32'(g.vld), 32'(e.vld));
    chk({tag, " latency"}, g.lat, e.lat);
    chk({tag, " stall_cycles"}, g.stalls, e.stalls);
    chk({tag, " alu_res_out"}, g.alu, e.alu);
    chk({tag, " dest_out"}, 32'(g.dest), 32'(e.dest));
    chk({tag, " wb_enable_out"}, 32'(g.wb), 32'(e.wb));
    chk({tag, " mem_read_enable_out"}, 32'(g.rd), 32'(e.rd));
`ifdef MEM_STAGE_ALIGN_CHK_EN
    chk({tag, " misaligned_out"}, 32'(g.mis), 32'(e.mis));
`endif
    if (e.chk_dmo) chk({tag, " data_memory_out"}, g.dmo, e.dmo);
  endtask

  initial begin
    vec_t        vecs [8];
    res_t        got, exp;
    op_t         op;
    logic [31:0] mdmo;
    bit          mkn;

    vecs[0] = '{'{32'd1024, 32'hDEADBEEF, 4'd1, 1'b0, 1'b0, 1'b1}, 32'h0,        1'b0};
    vecs[1] = '{'{32'd1024, 32'h0,        4'd2, 1'b1, 1'b1, 1'b0}, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{'{32'h55,   32'h0,        4'd3, 1'b1, 1'b0, 1'b0}, 32'h0,        1'b0};
    vecs[3] = '{'{32'd1280, 32'h11,       4'd4, 1'b0, 1'b0, 1'b1}, 32'h0,        1'b0};
    vecs[4] = '{'{32'd1024, 32'h0,        4'd5, 1'b1, 1'b1, 1'b0}, 32'h11,       1'b1};
    vecs[5] = '{'{32'd1032, 32'h5,        4'd6, 1'b1, 1'b1, 1'b1}, 32'h0,        1'b0};
    vecs[6] = '{'{32'd1032, 32'h0,        4'd7, 1'b1, 1'b1, 1'b0}, 32'h5,        1'b1};
    vecs[7] = '{'{32'd1028, 32'hAB,       4'd8, 1'b0, 1'b0, 1'b1}, 32'h0,        1'b0};

    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // Reset, with a memory op offered so stall must still read 0.
    rst = 1'b0;
    op = '{32'd1024, 32'h1, 4'd1, 1'b1, 1'b1, 1'b0};
    drive_op(op);
    #12;
    chk("reset valid_out", 32'(valid_out), 32'd0);
    chk("reset alu_res_out", alu_res_out, 32'd0);
    chk("reset data_memory_out", data_memory_out, 32'd0);
    chk("reset dest/wb/rd/stall", {24'd0, dest_out, wb_enable_out, mem_read_enable_out, stall_out, 1'b0}, 32'd0);
    drive_junk();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, got);
      exp     = rule_exp(vecs[i].op);
      exp.dmo = vecs[i].exp_dmo;
      exp.rd  = vecs[i].exp_rd;
      compare_res($sformatf("vec%0d", i), got, exp);
      model_apply(vecs[i].op, mdmo, mkn);
    end

    @(negedge clk);
    chk("bubble valid_out", 32'(valid_out), 32'd0);
    chk("bubble wb_enable_out", 32'(wb_enable_out), 32'd0);

    // Store 0x77 @1028 aborted by reset in its second BUSY cycle.
    op = '{32'd1028, 32'h77, 4'd9, 1'b0, 1'b0, 1'b1};
    drive_op(op);
    @(posedge clk);
    @(negedge clk);
    drive_junk();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort valid_out", 32'(valid_out), 32'd0);
    chk("abort stall_out", 32'(stall_out), 32'd0);
    chk("abort alu_res_out", alu_res_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    op = '{32'd1028, 32'h0, 4'd10, 1'b1, 1'b1, 1'b0};
    do_op(op, got);
    exp     = rule_exp(op);
    model_apply(op, exp.dmo, exp.chk_dmo);
    compare_res("post_abort_load", got, exp);
    chk("post_abort_load value", got.dmo, 32'hAB);

`ifdef MEM_STAGE_ALIGN_CHK_EN
    op = '{32'd1025, 32'h99, 4'd11, 1'b1, 1'b0, 1'b1};
    do_op(op, got);
    exp = rule_exp(op);
    model_apply(op, exp.dmo, exp.chk_dmo);
    compare_res("misaligned_store", got, exp);
    op = '{32'd1024, 32'h0, 4'd12, 1'b1, 1'b1, 1'b0};
    do_op(op, got);
    exp = rule_exp(op);
    model_apply(op, exp.dmo, exp.chk_dmo);
    compare_res("after_misaligned_load", got, exp);
    chk("after_misaligned_load value", got.dmo, 32'h11);
`endif

    for (int i = 0; i < 60; i++) begin
      op.addr = BASE + ($urandom_range(0, 127) << 2);
      if ($urandom_range(0, 7) == 0) op.addr = op.addr + $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) op.addr = $urandom;
      op.data = $urandom;
      op.dest = 4'($urandom);
      op.wb   = 1'($urandom);
      op.rd   = 1'($urandom);
      op.wr   = ($urandom_range(0, 2) == 0);
      do_op(op, got);
      exp = rule_exp(op);
      model_apply(op, exp.dmo, exp.chk_dmo);
      compare_res($sformatf("rnd%0d", i), got, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
